// File: rtl/box_plot_datapath.sv
// Box-drawing datapath behind the plot controller: latches origin and colour,
// then sweeps a 2^BOX_LOG2 square of pixels to the VGA adapter, one per clock.
module box_plot_datapath #(
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned C_W      = 3,
    parameter int unsigned DIN_W    = 7,
    parameter int unsigned BOX_LOG2 = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [DIN_W-1:0] data_in,
    input  logic [C_W-1:0]   colour_in,
    input  logic             ld_x,
    input  logic             ld_y,
    input  logic             ld_colour,
    input  logic             writeEn,
    output logic [X_W-1:0]   x_out,
    output logic [Y_W-1:0]   y_out,
    output logic [C_W-1:0]   colour_out,
    output logic             plot,
    output logic             done
);

    localparam int unsigned CNT_W = 2 * BOX_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [X_W-1:0]   x_reg;
    logic [Y_W-1:0]   y_reg;
    logic [C_W-1:0]   c_reg;
    logic             load_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Sweep sequencing; dropping writeEn mid-sweep aborts back to pixel 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (writeEn) state_nxt = DRAW;
            end
            DRAW: begin
                if (!writeEn) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == {CNT_W{1'b1}}) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                cnt_nxt = '0;
                if (!writeEn) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Origin/colour are frozen while a sweep is in flight.
    assign load_ok = (state != DRAW);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_reg <= '0;
            y_reg <= '0;
            c_reg <= '0;
        end else if (load_ok) begin
            if (ld_x)      x_reg <= X_W'(data_in);
            if (ld_y)      y_reg <= data_in[Y_W-1:0];
            if (ld_colour) c_reg <= colour_in;
        end
    end

    // Raster scan: low counter bits select the column, high bits the row.
    assign x_out      = x_reg + X_W'(cnt[BOX_LOG2-1:0]);
    assign y_out      = y_reg + Y_W'(cnt[CNT_W-1:BOX_LOG2]);
    assign colour_out = c_reg;
    assign plot       = (state == DRAW);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_box_plot_datapath.sv
// Directed, self-checking bench for box_plot_datapath (default 4x4 box).
module tb_box_plot_datapath;

    logic       clk = 1'b0;
    logic       resetn;
    logic [6:0] data_in;
    logic [2:0] colour_in;
    logic       ld_x, ld_y, ld_colour, writeEn;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot, done;

    int checks   = 0;
    int failures = 0;

    box_plot_datapath dut (
        .clk        (clk),
        .resetn     (resetn),
        .data_in    (data_in),
        .colour_in  (colour_in),
        .ld_x       (ld_x),
        .ld_y       (ld_y),
        .ld_colour  (ld_colour),
        .writeEn    (writeEn),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       lx, ly, lc;
        logic [6:0] d;
        logic [2:0] c;
        int         ex, ey, ec;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string name, input int ex, input int ey, input int ec,
                           input int ep, input int ed);
        chk({name, ".x"}, int'(x_out), ex);
        chk({name, ".y"}, int'(y_out), ey);
        chk({name, ".colour"}, int'(colour_out), ec);
        chk({name, ".plot"}, int'(plot), ep);
        chk({name, ".done"}, int'(done), ed);
    endtask

    // Expected pixel i of a sweep from (x0,y0): column fastest, wraps per width.
    task automatic chk_px(input string name, input int i, input int x0, input int y0,
                          input int c0);
        chk_all(name, (x0 + i % 4) % 256, (y0 + i / 4) % 128, c0, 1, 0);
    endtask

    task automatic load(input logic lx, input logic ly, input logic lc,
                        input logic [6:0] d, input logic [2:0] c);
        ld_x = lx; ld_y = ly; ld_colour = lc; data_in = d; colour_in = c;
        step();
        ld_x = 1'b0; ld_y = 1'b0; ld_colour = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 7'd5,   3'd0, 5,   0,   0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 7'd10,  3'd0, 5,   10,  0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 7'd99,  3'd5, 5,   10,  5};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 7'd20,  3'd2, 20,  20,  2};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 7'd127, 3'd7, 127, 20,  2};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 7'd126, 3'd1, 127, 126, 2};

        // Reset held with inputs toggling
        resetn = 1'b0;
        ld_x = 0; ld_y = 0; ld_colour = 0; writeEn = 0; data_in = 0; colour_in = 0;
        for (int i = 0; i < 5; i++) begin
            data_in = 7'($urandom); colour_in = 3'($urandom);
            ld_x = 1'($urandom); ld_y = 1'($urandom); ld_colour = 1'($urandom);
            writeEn = 1'($urandom);
            step();
            chk_all("reset_hold", 0, 0, 0, 0, 0);
        end
        ld_x = 0; ld_y = 0; ld_colour = 0; writeEn = 0; data_in = 0; colour_in = 0;
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("idle.plot", int'(plot), 0);
            chk("idle.done", int'(done), 0);
        end

        // Load table in IDLE
        for (int i = 0; i < 6; i++) begin
            load(tbl[i].lx, tbl[i].ly, tbl[i].lc, tbl[i].d, tbl[i].c);
            chk_all($sformatf("load_vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ec, 0, 0);
        end

        // Full box at (5,10) colour 5, with ld_x pulses mid-DRAW and in DONE
        load(1'b1, 1'b0, 1'b1, 7'd5, 3'd5);
        load(1'b0, 1'b1, 1'b0, 7'd10, 3'd0);
        chk_all("box_origin", 5, 10, 5, 0, 0);
        writeEn = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (i == 7 || i == 21) begin ld_x = 1'b1; data_in = 7'd40; end
            else ld_x = 1'b0;
            step();
            if (i < 16) chk_px($sformatf("box_px%0d", i), i, 5, 10, 5);
            else chk_all($sformatf("box_done%0d", i), (i >= 21) ? 40 : 5, 10, 5, 0, 1);
        end
        ld_x = 1'b0;
        writeEn = 1'b0;
        step();
        chk_all("box_release", 40, 10, 5, 0, 0);

        // Abort after 5 pixels, then restart from pixel 0
        load(1'b1, 1'b0, 1'b0, 7'd5, 3'd0);
        writeEn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_px($sformatf("abort_px%0d", i), i, 5, 10, 5);
        end
        writeEn = 1'b0;
        step();
        chk_all("abort_idle", 5, 10, 5, 0, 0);
        writeEn = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step();
            if (i < 16) chk_px($sformatf("restart_px%0d", i), i, 5, 10, 5);
            else chk_all("restart_done", 5, 10, 5, 0, 1);
        end
        writeEn = 1'b0;
        step();

        // Wrap-around: y=126, x=127 loaded together with writeEn
        load(1'b0, 1'b1, 1'b0, 7'd126, 3'd0);
        ld_x = 1'b1; data_in = 7'd127; writeEn = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step();
            ld_x = 1'b0;
            if (i < 16) chk_px($sformatf("wrap_px%0d", i), i, 127, 126, 5);
            else chk_all("wrap_done", 127, 126, 5, 0, 1);
        end
        writeEn = 1'b0;
        step();

        // Asynchronous reset between edges mid-DRAW
        writeEn = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk_px("pre_areset", 2, 127, 126, 5);
        #2;
        resetn = 1'b0;
        #1;
        chk_all("areset_async", 0, 0, 0, 0, 0);
        writeEn = 1'b0;
        step();
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("post_areset", 0, 0, 0, 0, 0);
        end
        writeEn = 1'b1;
        step();
        chk_px("post_areset_draw", 0, 0, 0, 0);
        writeEn = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/box_plot_datapath.md
# box_plot_datapath

Datapath stage directly downstream of the Simon Says plot controller. It consumes the controller's `ld_x`, `ld_y`, `ld_colour` and `writeEn` strobes and latches an origin coordinate and colour from the board inputs. On `writeEn` it sweeps a square box of pixels, one per clock, driving the VGA adapter's `x`, `y`, `colour` and `plot` inputs. It reports completion so the draw happens exactly once per `writeEn` assertion.

## Interface
- `X_W`, 8: width of the VGA x coordinate.
- `Y_W`, 7: width of the VGA y coordinate.
- `C_W`, 3: colour width.
- `DIN_W`, 7: width of the switch data input; must satisfy `DIN_W` ≤ `X_W` and `DIN_W` ≥ `Y_W`.
- `BOX_LOG2`, 2: log2 of the box side length; default box is 4×4 = 16 pixels.

Ports:
- `clk`  in  1  system clock; the only clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `data_in`  in  `DIN_W`  coordinate value from the switches.
- `colour_in`  in  `C_W`  colour from the switches.
- `ld_x`  in  1  load x origin.
- `ld_y`  in  1  load y origin.
- `ld_colour`  in  1  load colour.
- `writeEn`  in  1  draw request, level-sensitive, held high by the controller.
- `x_out`  out  `X_W`  pixel x to the VGA adapter.
- `y_out`  out  `Y_W`  pixel y to the VGA adapter.
- `colour_out`  out  `C_W`  pixel colour.
- `plot`  out  1  VGA write strobe; one pixel per cycle while high.
- `done`  out  1  box fully drawn; stays high until `writeEn` drops.

## Operation
- Registers:
  - `x_reg` (`X_W`), `y_reg` (`Y_W`), `c_reg` (`C_W`).
  - Pixel counter `cnt` (2·`BOX_LOG2` bits).
  - State register: IDLE, DRAW, DONE.
- Loads:
  - Loads are accepted only in IDLE and DONE, and are ignored in DRAW.
  - `ld_x`: `x_reg` ← `data_in`, zero-extended to `X_W`.
  - `ld_y`: `y_reg` ← `data_in[Y_W-1:0]`.
  - `ld_colour`: `c_reg` ← `colour_in`.
  - The load strobes are independent; any combination may load in the same cycle.
- State machine:
  - IDLE: `cnt` = 0. Go to DRAW if `writeEn` = 1, else stay.
  - DRAW: `plot` = 1. If `writeEn` = 0, go to IDLE and clear `cnt` (abort). Else if `cnt` = 2^(2·`BOX_LOG2`)−1, go to DONE and clear `cnt`. Else increment `cnt`.
  - DONE: `done` = 1 and `plot` = 0. Go to IDLE when `writeEn` = 0; holding `writeEn` high never re-draws.
- Pixel addressing:
  - Column = `cnt[BOX_LOG2-1:0]`, row = `cnt[2·BOX_LOG2-1:BOX_LOG2]`.
  - Scan order is raster: column fastest.
- Output arithmetic:
  - `x_out` = `x_reg` + column, truncated to `X_W` bits.
  - `y_out` = `y_reg` + row, truncated to `Y_W` bits.
  - Both wrap modulo 2^width; no clipping or saturation.
  - `colour_out` = `c_reg`.
- Outputs are decoded from registers only; there is no combinational path from any input to any output.

## Timing
- Reset values: state IDLE, `cnt` = 0, `x_reg` = `y_reg` = `c_reg` = 0. Hence `x_out` = 0, `y_out` = 0, `colour_out` = 0, `plot` = 0, `done` = 0.
- Asserting `resetn` low forces these values immediately, without a clock edge, in any state including mid-DRAW.
- Load latency: a load strobe sampled at edge k is visible on `x_out`/`y_out`/`colour_out` after edge k.
- Draw timing:
  - `writeEn` sampled high at edge k in IDLE: `plot` is high for the 2^(2·`BOX_LOG2`) cycles after edges k … k+15 (default).
  - The first pixel is at (`x_reg`, `y_reg`).
  - `done` rises after edge k+16 and `plot` is low in that same cycle.
- Abort timing:
  - `writeEn` sampled low at any DRAW edge: `plot` is low after that edge, the state is IDLE, and `cnt` = 0.
  - A later `writeEn` restarts the draw from pixel 0.
- In IDLE and DONE, `x_out`/`y_out` show the origin (`cnt` = 0).
- Simultaneous `writeEn` and a load in IDLE: the load takes effect, and the first DRAW pixel uses the newly loaded value.

## Test plan
- **Reset:** hold `resetn` = 0 with random inputs toggling → all outputs 0; release, no stimulus → `plot` = 0 and `done` = 0 indefinitely.
- **Full box:**
  - Stimulus: load x = 5, y = 10, colour = 3'b101; then hold `writeEn` for 25 cycles.
  - Required: exactly 16 `plot` cycles with (x, y) = (5,10), (6,10), (7,10), (8,10), (5,11) … (8,13), all with `colour_out` = 101.
  - Required: `done` high from the 17th cycle until `writeEn` falls; no second sweep.
- **Abort:**
  - Stimulus: drop `writeEn` after 5 `plot` cycles, then reassert it.
  - Required: `plot` is low the next cycle, `done` never rises, and the restarted sweep begins at (5,10) and completes 16 pixels.
- **Wrap-around:**
  - Stimulus: y = 126, x = 127, draw.
  - Required: `y_out` rows are 126, 127, 0, 1.
  - Required: `x_out` columns are 127, 128, 129, 130 (no x overflow at `X_W` = 8).
- **Load gating:**
  - Stimulus: pulse `ld_x` with `data_in` = 40 mid-DRAW.
  - Required: sweep columns unchanged and `x_reg` still 5.
  - Stimulus: the same pulse in DONE → `x_out` = 40 the next cycle.
- **Asynchronous reset mid-draw:** drop `resetn` between clock edges during DRAW → `plot`, `x_out` and `y_out` go to 0 before the next edge; after release the block is in IDLE.
